counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 127 ++++++++++++
 tb/tb_counter_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends a single up-counter to the winner.
// The owner sees a count from 0 to its latched limit, then a one-cycle done pulse.
module counter_arbiter #(
  parameter int W         = 4,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] lim0,
  input  logic [W-1:0] lim1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] a,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t         state_r;
  logic           owner_r;
  logic           ptr_r;
  logic [W-1:0]   lim_q_r;
  logic           pick1_s;
  logic           owner_req_s;

  // Arbitration choice and the current owner's request line.
  always_comb begin
    pick1_s     = 1'b0;
    owner_req_s = 1'b0;
    if (req0 && req1) begin
      pick1_s = ptr_r;
    end else if (req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    if (owner_r) begin
      owner_req_s = req1;
    end else begin
      owner_req_s = req0;
    end
  end

  // Control FSM; every output is driven from this register block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      ptr_r   <= PRIO_INIT;
      lim_q_r <= ZERO;
      a       <= ZERO;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          a     <= ZERO;
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            state_r <= COUNT;
            owner_r <= pick1_s;
            gnt0    <= ~pick1_s;
            gnt1    <= pick1_s;
            lim_q_r <= pick1_s ? lim1 : lim0;
            busy    <= 1'b1;
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            busy <= 1'b0;
          end
        end
        COUNT: begin
          if (!owner_req_s) begin
            // Abort: release immediately, no completion pulse.
            state_r <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            a       <= ZERO;
            busy    <= 1'b0;
            ptr_r   <= ~owner_r;
          end else if (a == lim_q_r) begin
            state_r <= DONE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= ~owner_r;
            done1   <= owner_r;
            ptr_r   <= ~owner_r;
          end else begin
            a <= a + ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done0   <= 1'b0;
          done1   <= 1'b0;
          a       <= ZERO;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          done0   <= 1'b0;
          done1   <= 1'b0;
          a       <= ZERO;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: stimulus queues cycle-stamped expected
// grant/done observations, a monitor pops and compares them as they appear.
module tb_counter_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [3:0] lim0;
  logic [3:0] lim1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [3:0] a;
  logic       busy;

  counter_arbiter #(.W(4), .PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lim0(lim0), .lim1(lim1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .a(a), .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic       g0;
    logic       g1;
    logic       d0;
    logic       d1;
    logic [3:0] av;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any cycle with a grant or done must match the queue head.
  always @(negedge clk) begin
    if (gnt0 || gnt1 || done0 || done1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out cyc=%0d got g0=%b g1=%b d0=%b d1=%b a=%0d, required no output",
                 cyc, gnt0, gnt1, done0, done1, a);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.g0 != gnt0 || e.g1 != gnt1 || e.d0 != done0 ||
            e.d1 != done1 || e.av != a || busy != 1'b1) begin
          errors++;
          $display("FAIL sb_out got cyc=%0d g0=%b g1=%b d0=%b d1=%b a=%0d busy=%b, required cyc=%0d g0=%b g1=%b d0=%b d1=%b a=%0d busy=1",
                   cyc, gnt0, gnt1, done0, done1, a, busy, e.cyc, e.g0, e.g1, e.d0, e.d1, e.av);
        end
      end
    end
  end

  task automatic push(input int c, input logic g0, input logic g1,
                      input logic d0, input logic d1, input int av);
    exp_t e;
    e.cyc = c; e.g0 = g0; e.g1 = g1; e.d0 = d0; e.d1 = d1; e.av = 4'(av);
    q.push_back(e);
  endtask

  // Full service: lim+1 grant cycles counting 0..lim, then a done holding lim.
  task automatic push_service(input bit who, input int start, input int lim);
    for (int i = 0; i <= lim; i++) push(start + i, !who, who, 1'b0, 1'b0, i);
    push(start + lim + 1, 1'b0, 1'b0, !who, who, lim);
  endtask

  task automatic wait_to(input int c);
    for (int k = 0; k < 200 && cyc < c; k++) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} != 5'b00000 || a != 4'd0) begin
      errors++;
      $display("FAIL %s cyc=%0d got g0=%b g1=%b d0=%b d1=%b a=%0d busy=%b, required all zero",
               name, cyc, gnt0, gnt1, done0, done1, a, busy);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lim0 = 4'd0; lim1 = 4'd0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;

    // Single requester, lim0=3.
    n = cyc;
    req0 = 1'b1; lim0 = 4'd3;
    push_service(1'b0, n + 1, 3);
    wait_to(n + 5); req0 = 1'b0;
    wait_to(n + 6); check_idle("single_idle");

    // Both requesting continuously: alternation 0,1,0,1 on a 4-cycle period.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    n = cyc;
    req0 = 1'b1; req1 = 1'b1; lim0 = 4'd1; lim1 = 4'd1;
    push_service(1'b0, n + 1, 1);
    push_service(1'b1, n + 5, 1);
    push_service(1'b0, n + 9, 1);
    push_service(1'b1, n + 13, 1);
    wait_to(n + 15); req0 = 1'b0; req1 = 1'b0;
    wait_to(n + 16); check_idle("alt_idle");

    // Abort at a=2, then ptr=1 shown by requester 1 winning; lim=0 services.
    n = cyc;
    req0 = 1'b1; lim0 = 4'd5;
    for (int i = 0; i < 3; i++) push(n + 1 + i, 1'b1, 1'b0, 1'b0, 1'b0, i);
    push_service(1'b1, n + 5, 0);
    push_service(1'b0, n + 8, 0);
    wait_to(n + 3); req0 = 1'b0;
    wait_to(n + 4); check_idle("abort_idle");
    req0 = 1'b1; req1 = 1'b1; lim0 = 4'd0; lim1 = 4'd0;
    wait_to(n + 6); req1 = 1'b0;
    wait_to(n + 9); req0 = 1'b0;
    wait_to(n + 10); check_idle("lim0_idle");

    // Full-range count, no wrap.
    n = cyc;
    req0 = 1'b1; lim0 = 4'd15;
    push_service(1'b0, n + 1, 15);
    wait_to(n + 17); req0 = 1'b0;
    wait_to(n + 18); check_idle("lim15_idle");

    // Reset during gnt1 at a=4 (ptr is 1 beforehand); afterwards ptr=0 wins.
    n = cyc;
    req1 = 1'b1; lim1 = 4'd7;
    for (int i = 0; i < 5; i++) push(n + 1 + i, 1'b0, 1'b1, 1'b0, 1'b0, i);
    push_service(1'b0, n + 7, 0);
    push_service(1'b1, n + 10, 1);
    wait_to(n + 5); rst = 1'b1;
    wait_to(n + 6); check_idle("rst_mid");
    rst = 1'b0; req0 = 1'b1; lim0 = 4'd0; lim1 = 4'd1;
    wait_to(n + 8); req0 = 1'b0;
    wait_to(n + 12); req1 = 1'b0;
    wait_to(n + 13); check_idle("post_rst_idle");

    // lim1 changed mid-service has no effect.
    n = cyc;
    req1 = 1'b1; lim1 = 4'd2;
    push_service(1'b1, n + 1, 2);
    wait_to(n + 1); lim1 = 4'd7;
    wait_to(n + 4); req1 = 1'b0;
    wait_to(n + 5); check_idle("lim_change_idle");

    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_out got %0d undelivered outputs, required 0 (first due cyc=%0d)",
               q.size(), q[0].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
